// File: rtl/itype_pkg.sv
// Shared decode constants, op enum and decoded-instruction bundle
// for the pipelined OP-IMM unit.
package itype_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef enum logic [3:0] {
      OP_ADD,
      OP_SLT,
      OP_SLTU,
      OP_XOR,
      OP_OR,
      OP_AND,
      OP_SLL,
      OP_SRL,
      OP_SRA
   } op_e;

   typedef struct packed {
      op_e         op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [11:0] imm;
      logic        illegal;
   } dec_t;

endpackage

// File: rtl/itype_alu.sv
// Combinational OP-IMM ALU, shared by the bypass and writeback paths.
// imm arrives already sign-extended to XLEN.
module itype_alu
   import itype_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  op_e             op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] result
);

   localparam int SHAMT_W = $clog2(XLEN);

   logic [SHAMT_W-1:0] shamt;
   logic               lt_s;
   logic               lt_u;

   assign shamt = imm[SHAMT_W-1:0];
   assign lt_s  = $signed(a) < $signed(imm);
   assign lt_u  = a < imm;

   always_comb begin
      result = '0;
      unique case (op)
         OP_ADD:  result = a + imm;
         OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
         OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
         OP_XOR:  result = a ^ imm;
         OP_OR:   result = a | imm;
         OP_AND:  result = a & imm;
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         OP_SRA:  result = $signed(a) >>> shamt;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/itype_pipe.sv
// Two-stage OP-IMM pipeline: S1 decode/read with bypass,
// S2 execute/writeback into an internal register file.
module itype_pipe
   import itype_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_data,
   output logic            out_illegal,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   localparam int AW = $clog2(NREG);
   localparam int UW = 12 - SHAMT_W;
   localparam logic [UW-1:0] SRA_UP = UW'(1) << (UW - 2);

   dec_t            dec;
   logic [UW-1:0]   upper;
   logic            adv;
   logic            s1_valid;
   logic            s2_valid;
   op_e             s1_op;
   logic [4:0]      s1_rd;
   logic [11:0]     s1_imm;
   logic            s1_ill;
   logic [XLEN-1:0] s1_a;
   logic [XLEN-1:0] s1_immx;
   logic [XLEN-1:0] s1_res;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] rf [NREG];

   assign adv       = !s2_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = s2_valid;
   assign upper     = instruction[31:20+SHAMT_W];

   always_comb begin
      dec.rd      = instruction[11:7];
      dec.rs1     = instruction[19:15];
      dec.imm     = instruction[31:20];
      dec.op      = OP_ADD;
      dec.illegal = instruction[6:0] != OPC_OP_IMM;
      unique case (instruction[14:12])
         F3_ADD:  dec.op = OP_ADD;
         F3_SLT:  dec.op = OP_SLT;
         F3_SLTU: dec.op = OP_SLTU;
         F3_XOR:  dec.op = OP_XOR;
         F3_OR:   dec.op = OP_OR;
         F3_AND:  dec.op = OP_AND;
         F3_SLL: begin
            dec.op = OP_SLL;
            if (upper != '0) dec.illegal = 1'b1;
         end
         F3_SR: begin
            dec.op = (upper == SRA_UP) ? OP_SRA : OP_SRL;
            if (upper != '0 && upper != SRA_UP)
               dec.illegal = 1'b1;
         end
      endcase
      if (32'(dec.rd) >= NREG || 32'(dec.rs1) >= NREG)
         dec.illegal = 1'b1;
   end

   assign rs1_val = rf[dec.rs1[AW-1:0]];

   // Forward the result still sitting in S1; it retires on the same edge.
   always_comb begin
      if (dec.rs1 == '0)
         op_a = '0;
      else if (s1_valid && s1_rd == dec.rs1 && !s1_ill && s1_rd != '0)
         op_a = s1_res;
      else
         op_a = rs1_val;
   end

   assign s1_immx = {{(XLEN-12){s1_imm[11]}}, s1_imm};

   itype_alu #(.XLEN(XLEN)) u_alu (
      .op     (s1_op),
      .a      (s1_a),
      .imm    (s1_immx),
      .result (s1_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_op       <= OP_ADD;
         s1_rd       <= '0;
         s1_imm      <= '0;
         s1_ill      <= 1'b0;
         s1_a        <= '0;
         s2_valid    <= 1'b0;
         out_rd      <= '0;
         out_data    <= '0;
         out_illegal <= 1'b0;
         rf          <= '{default: '0};
      end else if (adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op  <= dec.op;
            s1_rd  <= dec.rd;
            s1_imm <= dec.imm;
            s1_ill <= dec.illegal;
            s1_a   <= op_a;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_rd      <= s1_rd;
            out_illegal <= s1_ill;
            out_data    <= s1_ill ? '0 : s1_res;
            if (!s1_ill && s1_rd != '0 && 32'(s1_rd) < NREG)
               rf[s1_rd[AW-1:0]] <= s1_res;
         end
      end
   end

   assign dbg_data = (dbg_addr == '0 || 32'(dbg_addr) >= NREG)
                   ? '0 : rf[dbg_addr[AW-1:0]];

endmodule

// File: tb/tb_itype_pipe.sv
// Directed bench for itype_pipe: bypass, ALU ops, stall, illegal
// encodings, x0, mid-flight reset and a 16-register build.
module tb_itype_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic        out_illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   logic        in_valid16;
   logic        in_ready16;
   logic [31:0] instr16;
   logic        out_valid16;
   logic        out_ready16;
   logic [4:0]  out_rd16;
   logic [31:0] out_data16;
   logic        out_illegal16;
   logic [4:0]  dbg_addr16;
   logic [31:0] dbg_data16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   itype_pipe #(.XLEN(32), .NREG(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_rd      (out_rd),
      .out_data    (out_data),
      .out_illegal (out_illegal),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   itype_pipe #(.XLEN(32), .NREG(16)) dut16 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid16),
      .in_ready    (in_ready16),
      .instruction (instr16),
      .out_valid   (out_valid16),
      .out_ready   (out_ready16),
      .out_rd      (out_rd16),
      .out_data    (out_data16),
      .out_illegal (out_illegal16),
      .dbg_addr    (dbg_addr16),
      .dbg_data    (dbg_data16)
   );

   function automatic logic [31:0] ienc(input logic [11:0] imm,
                                        input logic [4:0]  rs1,
                                        input logic [2:0]  f3,
                                        input logic [4:0]  rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins);
      in_valid    = 1'b1;
      instruction = ins;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic out_chk(input string tag,
                          input logic [4:0]  rd,
                          input logic [31:0] data,
                          input logic        ill);
      chk({tag, ".valid"}, out_valid, 1'b1);
      chk({tag, ".rd"}, out_rd, rd);
      chk({tag, ".data"}, out_data, data);
      chk({tag, ".ill"}, out_illegal, ill);
   endtask

   task automatic dbg_chk(input string tag,
                          input logic [4:0]  a,
                          input logic [31:0] exp);
      dbg_addr = a;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      instruction = '0;
      out_ready   = 1'b1;
      dbg_addr    = '0;
      in_valid16  = 1'b0;
      instr16     = '0;
      out_ready16 = 1'b1;
      dbg_addr16  = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", out_valid, 1'b0);
      chk("rst.rd", out_rd, 5'd0);
      chk("rst.data", out_data, 32'h0);
      chk("rst.ill", out_illegal, 1'b0);
      rst = 1'b0;
      #1;
      chk("rst.in_ready", in_ready, 1'b1);
      dbg_chk("rst.dbg5", 5'd5, 32'h0);

      // ADDI x1,x0,5 ; ADDI x2,x1,-7 back to back
      issue(ienc(12'd5, 5'd0, 3'b000, 5'd1));
      chk("t1.lat", out_valid, 1'b0);
      issue(ienc(12'hFF9, 5'd1, 3'b000, 5'd2));
      out_chk("t1.a", 5'd1, 32'd5, 1'b0);
      idle();
      out_chk("t1.b", 5'd2, 32'hFFFF_FFFE, 1'b0);
      dbg_chk("t1.dbg2", 5'd2, 32'hFFFF_FFFE);
      idle();
      chk("t1.drain", out_valid, 1'b0);

      // x3 = 0x80000000, then shifts and compares
      issue(ienc(12'd1, 5'd0, 3'b000, 5'd3));
      issue(ienc(12'h01F, 5'd3, 3'b001, 5'd3));
      out_chk("t2.addi", 5'd3, 32'd1, 1'b0);
      issue(ienc(12'h404, 5'd3, 3'b101, 5'd4));
      out_chk("t2.slli", 5'd3, 32'h8000_0000, 1'b0);
      issue(ienc(12'h004, 5'd3, 3'b101, 5'd5));
      out_chk("t2.srai", 5'd4, 32'hF800_0000, 1'b0);
      issue(ienc(12'h000, 5'd3, 3'b010, 5'd6));
      out_chk("t2.srli", 5'd5, 32'h0800_0000, 1'b0);
      issue(ienc(12'hFFF, 5'd3, 3'b011, 5'd7));
      out_chk("t2.slti", 5'd6, 32'd1, 1'b0);
      idle();
      out_chk("t2.sltiu", 5'd7, 32'd1, 1'b0);

      // stall with two instructions queued
      issue(ienc(12'd10, 5'd0, 3'b000, 5'd8));
      issue(ienc(12'd20, 5'd0, 3'b000, 5'd9));
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      instruction = ienc(12'd30, 5'd0, 3'b000, 5'd10);
      #1;
      chk("t3.in_ready", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         out_chk("t3.hold", 5'd8, 32'd10, 1'b0);
         chk("t3.hold.in_ready", in_ready, 1'b0);
      end
      dbg_chk("t3.dbg9", 5'd9, 32'h0);
      dbg_chk("t3.dbg10", 5'd10, 32'h0);
      out_ready = 1'b1;
      tick();
      out_chk("t3.r1", 5'd9, 32'd20, 1'b0);
      idle();
      out_chk("t3.r2", 5'd10, 32'd30, 1'b0);
      idle();
      chk("t3.drain", out_valid, 1'b0);
      dbg_chk("t3.dbg10b", 5'd10, 32'd30);

      // illegal encodings, and no bypass from an illegal result
      issue({7'b0, 5'd1, 5'd1, 3'b000, 5'd2, 7'b0110011});
      issue(ienc(12'h021, 5'd1, 3'b001, 5'd1));
      out_chk("t4.rtype", 5'd2, 32'h0, 1'b1);
      issue(ienc(12'h000, 5'd1, 3'b000, 5'd13));
      out_chk("t4.slli", 5'd1, 32'h0, 1'b1);
      issue(ienc(12'h003, 5'd1, 3'b100, 5'd15));
      out_chk("t4.addi", 5'd13, 32'd5, 1'b0);
      dbg_chk("t4.dbg1", 5'd1, 32'd5);
      dbg_chk("t4.dbg2", 5'd2, 32'hFFFF_FFFE);

      // logic ops on x1=5
      issue(ienc(12'h010, 5'd1, 3'b110, 5'd16));
      out_chk("t5.xori", 5'd15, 32'd6, 1'b0);
      issue(ienc(12'h004, 5'd1, 3'b111, 5'd17));
      out_chk("t5.ori", 5'd16, 32'h15, 1'b0);
      idle();
      out_chk("t5.andi", 5'd17, 32'd4, 1'b0);

      // ADDI x0,x0,9
      issue(ienc(12'd9, 5'd0, 3'b000, 5'd0));
      idle();
      out_chk("t6.x0", 5'd0, 32'd9, 1'b0);
      dbg_chk("t6.dbg0", 5'd0, 32'h0);

      // reset with two instructions in flight
      issue(ienc(12'd7, 5'd0, 3'b000, 5'd18));
      issue(ienc(12'd8, 5'd0, 3'b000, 5'd19));
      chk("t7.pre", out_valid, 1'b1);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("t7.valid", out_valid, 1'b0);
      chk("t7.data", out_data, 32'h0);
      tick();
      rst = 1'b0;
      dbg_chk("t7.dbg1", 5'd1, 32'h0);
      dbg_chk("t7.dbg2", 5'd2, 32'h0);
      dbg_chk("t7.dbg18", 5'd18, 32'h0);
      tick();
      chk("t7.idle", out_valid, 1'b0);
      dbg_chk("t7.dbg19", 5'd19, 32'h0);

      // 16-register build: rd=17 is illegal
      in_valid16 = 1'b1;
      instr16    = ienc(12'd1, 5'd0, 3'b000, 5'd17);
      tick();
      instr16 = ienc(12'd3, 5'd0, 3'b000, 5'd5);
      tick();
      chk("n16.ill", out_illegal16, 1'b1);
      chk("n16.ill.data", out_data16, 32'h0);
      chk("n16.ill.rd", out_rd16, 5'd17);
      in_valid16 = 1'b0;
      tick();
      chk("n16.ok", out_illegal16, 1'b0);
      chk("n16.ok.data", out_data16, 32'd3);
      dbg_addr16 = 5'd5;
      #1;
      chk("n16.dbg5", dbg_data16, 32'd3);
      dbg_addr16 = 5'd17;
      #1;
      chk("n16.dbg17", dbg_data16, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
